spw_babasu_pio_out_pulse: RTL

//  Parametrised Avalon-MM slave output port for SpaceWire control strobes (autostart, link enable, etc.).
//  It replaces single-bit PIOs with one WIDTH-bit port.

---
 rtl/spw_babasu_pio_out_pulse.sv | 80 ++++++++
 1 files changed

// File: rtl/spw_babasu_pio_out_pulse.sv
// Avalon-MM output port for SpaceWire control strobes.
// Supports atomic bit set/clear and timed one-shot pulses that clear themselves.
module spw_babasu_pio_out_pulse #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int unsigned      PULSE_LEN   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port,
   output logic             pulse_busy
);

   localparam int unsigned   CW       = $clog2(PULSE_LEN + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_SET    = 3'd1;
   localparam logic [2:0] ADDR_CLEAR  = 3'd2;
   localparam logic [2:0] ADDR_PULSE  = 3'd3;
   localparam logic [2:0] ADDR_STATUS = 3'd4;

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] pmask_q;
   logic [CW-1:0]    cnt_q;
   logic             wr;
   logic [WIDTH-1:0] wd;
   logic             pulse_active;

   assign wr           = chipselect & ~write_n;
   assign wd           = writedata[WIDTH-1:0];
   assign pulse_active = (cnt_q != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= RESET_VALUE;
         pmask_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (wr) begin
            case (address)
               ADDR_DATA:  data_q <= wd;
               ADDR_SET:   data_q <= data_q | wd;
               ADDR_CLEAR: data_q <= data_q & ~wd;
               default:    ;
            endcase
         end
         // A PULSE write overrides the countdown, including on the expiry edge.
         if (wr && (address == ADDR_PULSE)) begin
            pmask_q <= wd;
            cnt_q   <= (wd != '0) ? CNT_LOAD : '0;
         end else if (pulse_active) begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               pmask_q <= '0;
            end
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata[WIDTH-1:0] = data_q;
         ADDR_PULSE:                      readdata[WIDTH-1:0] = pmask_q;
         ADDR_STATUS:                     readdata[0]         = pulse_active;
         default:                         ;
      endcase
   end

   assign out_port   = data_q | (pulse_active ? pmask_q : '0);
   assign pulse_busy = pulse_active;

endmodule
